uncache_axi_bridge: RTL

//  Memory-side responder for CPU data accesses that address translation marks uncached
//  (kseg1, no_dcache=1). Accepts one SRAM-like request at a time on the physical address.

---
 rtl/uncache_axi_bridge_pkg.sv | 21 ++
 rtl/uncache_axi_bridge.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uncache_axi_bridge_pkg.sv
// Shared AXI encodings and FSM state type for the uncached data-access bridge.
package uncache_axi_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY  = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR  = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR  = 2'b11;
  localparam logic [3:0] AXI_CACHE_DEVICE = 4'b0000;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
  localparam logic [7:0] AXI_LEN_SINGLE   = 8'd0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } state_t;

endpackage

// File: rtl/uncache_axi_bridge.sv
// Uncached CPU data access to single-beat AXI4 transfer; one request in flight at a time.
// state      | meaning
// ST_IDLE    | ready for a CPU request, cpu_addr_ok follows cpu_req
// ST_RD_ADDR | arvalid held until arready
// ST_RD_DATA | rready high, waiting for rvalid
// ST_WR_REQ  | awvalid/wvalid each held until their own handshake
// ST_WR_RESP | bready high, waiting for bvalid
module uncache_axi_bridge
  import uncache_axi_bridge_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int AXI_ID = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            cpu_req,
  input  logic            cpu_wr,
  input  logic [1:0]      cpu_size,
  input  logic [31:0]     cpu_addr,
  input  logic [31:0]     cpu_wdata,
  input  logic [3:0]      cpu_wstrb,
  output logic            cpu_addr_ok,
  output logic            cpu_data_ok,
  output logic [31:0]     cpu_rdata,
  output logic            cpu_err,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic            awvalid,
  input  logic            awready,
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic        aw_done, w_done, data_ok_q;
  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic        unused_inputs;

  assign ar_hs = arvalid & arready;
  assign r_hs  = rready  & rvalid;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid  & wready;
  assign b_hs  = bready  & bvalid;

  // ids are not checked on return and only resp[1] distinguishes an error
  assign unused_inputs = ^{rid, bid, rlast, rresp[0], bresp[0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (cpu_req) state_nxt = cpu_wr ? ST_WR_REQ : ST_RD_ADDR;
      ST_RD_ADDR: if (ar_hs)   state_nxt = ST_RD_DATA;
      ST_RD_DATA: if (r_hs)    state_nxt = ST_IDLE;
      ST_WR_REQ:  if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = ST_WR_RESP;
      ST_WR_RESP: if (b_hs)    state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_addr_ok = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    case (state)
      ST_IDLE:    cpu_addr_ok = cpu_req;
      ST_RD_ADDR: arvalid     = 1'b1;
      ST_RD_DATA: rready      = 1'b1;
      ST_WR_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
      end
      ST_WR_RESP: bready      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      data_ok_q <= 1'b0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
    end else begin
      data_ok_q <= r_hs | b_hs;
      if (cpu_addr_ok) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        size_q  <= cpu_size;
        wstrb_q <= cpu_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (r_hs) begin
        cpu_rdata <= rdata;
        cpu_err   <= rresp[1];
      end
      if (b_hs) cpu_err <= bresp[1];
    end
  end

  assign cpu_data_ok = data_ok_q;

  assign arid    = ID_W'(AXI_ID);
  assign araddr  = addr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = {1'b0, size_q};
  assign arburst = AXI_BURST_INCR;
  assign arcache = AXI_CACHE_DEVICE;
  assign arprot  = AXI_PROT_DEFAULT;

  assign awid    = ID_W'(AXI_ID);
  assign awaddr  = addr_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = {1'b0, size_q};
  assign awburst = AXI_BURST_INCR;
  assign awcache = AXI_CACHE_DEVICE;
  assign awprot  = AXI_PROT_DEFAULT;

  assign wid     = ID_W'(AXI_ID);
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

  a_legal_size: assert property (@(posedge clk) disable iff (!resetn)
    cpu_addr_ok |-> cpu_size != 2'd3);

endmodule
